// File: rtl/cronometro_param.sv
// Synchronous MM:SS stopwatch with run/pause, clear, lap freeze and rollover pulse.
// Define CRONO_HOURS_EN to add an HH pair (00-23) and the disp5/disp6 outputs.
module cronometro_param #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic       running,
  output logic       rollover,
  output logic [6:0] disp1,
  output logic [6:0] disp2,
  output logic [6:0] disp3,
`ifdef CRONO_HOURS_EN
  output logic [6:0] disp4,
  output logic [6:0] disp5,
  output logic [6:0] disp6
`else
  output logic [6:0] disp4
`endif
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
      $error("cronometro_param: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
  endgenerate

  // Active-high a..g pattern for one BCD digit; blank for non-decimal codes.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'b0111111;
      4'd1: p = 7'b0000110;
      4'd2: p = 7'b1011011;
      4'd3: p = 7'b1001111;
      4'd4: p = 7'b1100110;
      4'd5: p = 7'b1101101;
      4'd6: p = 7'b1111101;
      4'd7: p = 7'b0000111;
      4'd8: p = 7'b1111111;
      4'd9: p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  logic [PW-1:0] presc;
  logic          run, frozen, tick;
  logic [3:0]    su, mu, su_nxt, mu_nxt, sh_su, sh_mu;
  logic [2:0]    st, mt, st_nxt, mt_nxt, sh_st, sh_mt;
  logic          en_st, en_mu, en_mt, en_h, wrap;
`ifdef CRONO_HOURS_EN
  logic [3:0]    hu, hu_nxt, sh_hu;
  logic [1:0]    ht, ht_nxt, sh_ht;
`endif

  assign tick  = run && (presc == PW'(DIV - 1));
  assign en_st = tick && (su == 4'd9);
  assign en_mu = en_st && (st == 3'd5);
  assign en_mt = en_mu && (mu == 4'd9);
  assign en_h  = en_mt && (mt == 3'd5);
`ifdef CRONO_HOURS_EN
  assign wrap  = en_h && (ht == 2'd2) && (hu == 4'd3);
`else
  assign wrap  = en_h;
`endif

  // Next value of each digit: advance on its enable, wrap at its maximum.
  always_comb begin
    su_nxt = su;
    st_nxt = st;
    mu_nxt = mu;
    mt_nxt = mt;
    if (tick) su_nxt = (su == 4'd9) ? 4'd0 : su + 4'd1;
    else      su_nxt = su;
    if (en_st) st_nxt = (st == 3'd5) ? 3'd0 : st + 3'd1;
    else       st_nxt = st;
    if (en_mu) mu_nxt = (mu == 4'd9) ? 4'd0 : mu + 4'd1;
    else       mu_nxt = mu;
    if (en_mt) mt_nxt = (mt == 3'd5) ? 3'd0 : mt + 3'd1;
    else       mt_nxt = mt;
`ifdef CRONO_HOURS_EN
    hu_nxt = hu;
    ht_nxt = ht;
    if (wrap) begin
      hu_nxt = 4'd0;
      ht_nxt = 2'd0;
    end else if (en_h) begin
      hu_nxt = (hu == 4'd9) ? 4'd0 : hu + 4'd1;
      ht_nxt = (hu == 4'd9) ? ht + 2'd1 : ht;
    end else begin
      hu_nxt = hu;
      ht_nxt = ht;
    end
`endif
  end

  // Run state, prescaler, live digits, lap shadow and rollover pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      run      <= 1'b0;
      presc    <= '0;
      frozen   <= 1'b0;
      rollover <= 1'b0;
      {su, st, mu, mt} <= '0;
      {sh_su, sh_st, sh_mu, sh_mt} <= '0;
`ifdef CRONO_HOURS_EN
      {hu, ht, sh_hu, sh_ht} <= '0;
`endif
    end else begin
      if (start_stop) run <= ~run;
      else            run <= run;
      if (clear) begin
        // A tick landing on the clear edge is dropped, so no rollover either.
        presc    <= '0;
        frozen   <= 1'b0;
        rollover <= 1'b0;
        {su, st, mu, mt} <= '0;
`ifdef CRONO_HOURS_EN
        {hu, ht} <= '0;
`endif
      end else begin
        if (run) presc <= tick ? '0 : presc + PW'(1);
        else     presc <= presc;
        rollover <= wrap;
        {su, st, mu, mt} <= {su_nxt, st_nxt, mu_nxt, mt_nxt};
`ifdef CRONO_HOURS_EN
        {hu, ht} <= {hu_nxt, ht_nxt};
`endif
        if (lap) begin
          frozen <= ~frozen;
          if (!frozen) begin
            {sh_su, sh_st, sh_mu, sh_mt} <= {su, st, mu, mt};
`ifdef CRONO_HOURS_EN
            {sh_hu, sh_ht} <= {hu, ht};
`endif
          end else begin
            {sh_su, sh_st, sh_mu, sh_mt} <= {sh_su, sh_st, sh_mu, sh_mt};
          end
        end else begin
          frozen <= frozen;
        end
      end
    end
  end

  assign running = run;

  // Display decode of either the live count or the frozen lap snapshot.
  always_comb begin
    disp1 = seg7(frozen ? sh_su : su);
    disp2 = seg7({1'b0, frozen ? sh_st : st});
    disp3 = seg7(frozen ? sh_mu : mu);
    disp4 = seg7({1'b0, frozen ? sh_mt : mt});
`ifdef CRONO_HOURS_EN
    disp5 = seg7(frozen ? sh_hu : hu);
    disp6 = seg7({2'b00, frozen ? sh_ht : ht});
`endif
  end

endmodule

// File: tb/tb_cronometro_param.sv
// Scoreboard bench for cronometro_param (DIV=4, active-low): a seconds-count model
// predicts every cycle's outputs; a monitor process pops and compares them.
module tb_cronometro_param;

  localparam int CLK_HZ = 4;
  localparam int TICK_HZ = 1;
  localparam int DIV = CLK_HZ / TICK_HZ;
`ifdef CRONO_HOURS_EN
  localparam int MAXS = 86400;
`else
  localparam int MAXS = 3600;
`endif

  logic clk = 1'b0, reset = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic running, rollover;
  logic [6:0] disp1, disp2, disp3, disp4;
`ifdef CRONO_HOURS_EN
  logic [6:0] disp5, disp6;
`endif

  cronometro_param #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .running(running), .rollover(rollover),
`ifdef CRONO_HOURS_EN
    .disp5(disp5), .disp6(disp6),
`endif
    .disp1(disp1), .disp2(disp2), .disp3(disp3), .disp4(disp4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] d6, d5, d4, d3, d2, d1;
    logic       run, roll;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: elapsed seconds as a plain integer.
  int m_secs = 0, m_presc = 0, m_shadow = 0;
  bit m_run = 1'b0, m_frz = 1'b0, m_roll = 1'b0;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    int s, h, m, sec;
    s   = m_frz ? m_shadow : m_secs;
    h   = s / 3600;
    m   = (s / 60) % 60;
    sec = s % 60;
    o.d1 = seg(sec % 10);
    o.d2 = seg(sec / 10);
    o.d3 = seg(m % 10);
    o.d4 = seg(m / 10);
`ifdef CRONO_HOURS_EN
    o.d5 = seg(h % 10);
    o.d6 = seg(h / 10);
`else
    o.d5 = seg(0);
    o.d6 = seg(0);
    if (h != 0) o.d5 = 7'b1111111;
`endif
    o.run  = m_run;
    o.roll = m_roll;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.d1 = disp1; o.d2 = disp2; o.d3 = disp3; o.d4 = disp4;
`ifdef CRONO_HOURS_EN
    o.d5 = disp5; o.d6 = disp6;
`else
    o.d5 = seg(0); o.d6 = seg(0);
`endif
    o.run  = running;
    o.roll = rollover;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue the prediction.
  task automatic step(input bit r, input bit ss, input bit cl, input bit lp);
    bit tick, nrun;
    @(negedge clk);
    reset = r; start_stop = ss; clear = cl; lap = lp;
    if (r) begin
      m_secs = 0; m_presc = 0; m_run = 1'b0; m_frz = 1'b0; m_roll = 1'b0; m_shadow = 0;
    end else begin
      tick = m_run && (m_presc == DIV - 1);
      nrun = ss ? !m_run : m_run;
      if (cl) begin
        m_secs = 0; m_presc = 0; m_frz = 1'b0; m_roll = 1'b0;
      end else begin
        if (lp) begin
          if (!m_frz) m_shadow = m_secs;
          m_frz = !m_frz;
        end
        if (m_run) m_presc = (m_presc + 1) % DIV;
        m_roll = 1'b0;
        if (tick) begin
          m_secs = (m_secs + 1) % MAXS;
          m_roll = (m_secs == 0);
        end
      end
      m_run = nrun;
    end
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are valid every cycle once a prediction is queued.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("scoreboard", 64'(dut_obs()), 64'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("reset_disp1", 64'(disp1), 64'(7'b1000000));
    chk("reset_disp4", 64'(disp4), 64'(7'b1000000));
    chk("reset_running", 64'(running), 64'(1'b0));

    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(40);
    settle();
    chk("ten_s_disp2", 64'(disp2), 64'(7'b1111001));
    chk("ten_s_disp1", 64'(disp1), 64'(7'b1000000));

    // 00:10 -> 59:58 is 3588 ticks, then two more ticks wrap.
    idle(3588 * DIV);
    idle(8);
    settle();
`ifdef CRONO_HOURS_EN
    chk("wrap_rollover", 64'(rollover), 64'(1'b0));
    chk("wrap_hours", 64'(disp5), 64'(7'b1111001));
`else
    chk("wrap_rollover", 64'(rollover), 64'(1'b1));
`endif
    chk("wrap_disp4", 64'(disp4), 64'(7'b1000000));
    idle(1);
    settle();
    chk("rollover_one_cycle", 64'(rollover), 64'(1'b0));

    // Pause holds count and prescaler; restart resumes mid-period.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(22);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(20);
    settle();
    chk("paused_disp1", 64'(disp1), 64'(7'b0010010));
    chk("paused_running", 64'(running), 64'(1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(12);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);

    guard = 0;
    while (!(m_run && m_presc == DIV - 1) && guard < 2 * DIV) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("clear_tick_disp1", 64'(disp1), 64'(7'b1000000));
    chk("clear_tick_rollover", 64'(rollover), 64'(1'b0));
    chk("clear_tick_running", 64'(running), 64'(1'b1));

    idle(30);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);
    settle();
    chk("reset_midrun_running", 64'(running), 64'(1'b0));
    chk("reset_midrun_disp1", 64'(disp1), 64'(7'b1000000));

    for (int i = 0; i < 8000; i++) begin
      step($urandom_range(499, 0) == 0, $urandom_range(39, 0) == 0,
           $urandom_range(149, 0) == 0, $urandom_range(24, 0) == 0);
    end
    idle(1);
    settle();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
